// File: rtl/fp_conv_pkg.sv
// Shared IEEE-754 single-precision constants and operand classification
// for the float-to-fixed conversion path.
package fp_conv_pkg;

  localparam int FP_BIAS   = 127;
  localparam int FP_MANT_W = 23;
  localparam int FP_EXP_W  = 8;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } fp_class_t;

  // Denormals are flushed to zero; an all-ones exponent splits on the mantissa.
  function automatic fp_class_t fp_classify(input logic [FP_EXP_W-1:0]  exp_f,
                                            input logic [FP_MANT_W-1:0] mant_f);
    fp_class_t cls;
    if (exp_f == {FP_EXP_W{1'b0}}) begin
      cls = ZERO;
    end else if (exp_f == {FP_EXP_W{1'b1}}) begin
      cls = (mant_f != {FP_MANT_W{1'b0}}) ? NAN : INF;
    end else begin
      cls = NORM;
    end
    return cls;
  endfunction

endpackage

// File: rtl/fp_align_shift.sv
// Aligns the 24-bit significand to the output binary point and produces
// guard/sticky bits for rounding plus a flag for bits above the sign position.
module fp_align_shift
  import fp_conv_pkg::*;
#(
  parameter int OUT_W = 22
) (
  input  logic [FP_MANT_W:0]   i_sig,
  input  logic signed [9:0]    i_sh,
  output logic [OUT_W-1:0]     o_mag,
  output logic                 o_g,
  output logic                 o_s,
  output logic                 o_hi
);

  localparam int W = OUT_W + 24;

  logic [W-1:0] w_val;
  logic [48:0]  w_rs;
  logic [9:0]   w_rsh;

  // Left shifts at or beyond OUT_W always land above the sign bit, so they
  // skip the shifter and only mark the top bit.
  always_comb begin
    w_val = {W{1'b0}};
    w_rs  = 49'd0;
    o_g   = 1'b0;
    o_s   = 1'b0;
    w_rsh = 10'd0 - i_sh;
    if (i_sh >= 10'sd0) begin
      if (int'(i_sh) >= OUT_W) begin
        w_val[W-1] = |i_sig;
      end else begin
        w_val = W'(i_sig) << i_sh[5:0];
      end
    end else if (w_rsh >= 10'd25) begin
      o_s = |i_sig;
    end else begin
      w_rs  = {i_sig, 25'd0} >> w_rsh[4:0];
      w_val = W'(w_rs[48:25]);
      o_g   = w_rs[24];
      o_s   = |w_rs[23:0];
    end
  end

  assign o_mag = w_val[OUT_W-1:0];
  assign o_hi  = |w_val[W-1:OUT_W];

endmodule

// File: rtl/fp_to_fixed_pipe.sv
// Three-stage IEEE-754 single to signed Q(OUT_W-FRAC_W).FRAC_W converter:
// unpack/classify, align, then round/negate/saturate into registered outputs.
module fp_to_fixed_pipe
  import fp_conv_pkg::*;
#(
  parameter int OUT_W      = 22,
  parameter int FRAC_W     = 20,
  parameter int ROUND_NEAR = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             in_valid,
  input  logic [31:0]      dataa,
  output logic             out_valid,
  output logic [OUT_W-1:0] result,
  output logic             ovf,
  output logic             nan
);

  localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MAX_NEG = {1'b1, {(OUT_W-1){1'b0}}};

  fp_class_t         w_class;
  logic signed [9:0] w_sh;

  logic              r1_valid, r1_sign;
  fp_class_t         r1_class;
  logic [FP_MANT_W:0] r1_sig;
  logic signed [9:0] r1_sh;

  logic [OUT_W-1:0]  w_mag;
  logic              w_g, w_s, w_hi;

  logic              r2_valid, r2_sign, r2_g, r2_s, r2_hi;
  fp_class_t         r2_class;
  logic [OUT_W-1:0]  r2_mag;

  logic              w_inc, w_over, w_pos_ovf, w_neg_ovf;
  logic [OUT_W:0]    w_sum;
  logic [OUT_W-1:0]  w_m, w_res;
  logic              w_ovf, w_nan;

  assign w_class = fp_classify(dataa[30:23], dataa[22:0]);
  assign w_sh    = $signed({2'b00, dataa[30:23]}) - 10'sd150 + 10'(FRAC_W);

  // S1: unpack and classify
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid <= 1'b0;
      r1_sign  <= 1'b0;
      r1_class <= ZERO;
      r1_sig   <= '0;
      r1_sh    <= 10'sd0;
    end else if (clk_en) begin
      r1_valid <= in_valid;
      r1_sign  <= dataa[31];
      r1_class <= w_class;
      r1_sig   <= {1'b1, dataa[22:0]};
      r1_sh    <= w_sh;
    end
  end

  fp_align_shift #(.OUT_W(OUT_W)) u_align (
    .i_sig (r1_sig),
    .i_sh  (r1_sh),
    .o_mag (w_mag),
    .o_g   (w_g),
    .o_s   (w_s),
    .o_hi  (w_hi)
  );

  // S2: aligned magnitude with guard/sticky
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_valid <= 1'b0;
      r2_sign  <= 1'b0;
      r2_class <= ZERO;
      r2_mag   <= '0;
      r2_g     <= 1'b0;
      r2_s     <= 1'b0;
      r2_hi    <= 1'b0;
    end else if (clk_en) begin
      r2_valid <= r1_valid;
      r2_sign  <= r1_sign;
      r2_class <= r1_class;
      r2_mag   <= w_mag;
      r2_g     <= w_g;
      r2_s     <= w_s;
      r2_hi    <= w_hi;
    end
  end

  // A magnitude of exactly 2^(OUT_W-1) still fits when negative, so overflow
  // is judged separately per sign after rounding.
  always_comb begin
    w_inc     = (ROUND_NEAR != 0) && r2_g && (r2_s || r2_mag[0]);
    w_sum     = {1'b0, r2_mag} + {{OUT_W{1'b0}}, w_inc};
    w_m       = w_sum[OUT_W-1:0];
    w_over    = r2_hi | w_sum[OUT_W];
    w_pos_ovf = w_over | w_m[OUT_W-1];
    w_neg_ovf = w_over | (w_m[OUT_W-1] & (|w_m[OUT_W-2:0]));
    w_res     = '0;
    w_ovf     = 1'b0;
    w_nan     = 1'b0;
    case (r2_class)
      NAN: begin
        w_nan = 1'b1;
      end
      INF: begin
        w_res = r2_sign ? MAX_NEG : MAX_POS;
        w_ovf = 1'b1;
      end
      NORM: begin
        if (r2_sign) begin
          w_res = w_neg_ovf ? MAX_NEG : (~w_m + {{(OUT_W-1){1'b0}}, 1'b1});
          w_ovf = w_neg_ovf;
        end else begin
          w_res = w_pos_ovf ? MAX_POS : w_m;
          w_ovf = w_pos_ovf;
        end
      end
      default: begin
        w_res = '0;
      end
    endcase
  end

  // S3: registered outputs; result and flags hold across bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
      nan       <= 1'b0;
    end else if (clk_en) begin
      out_valid <= r2_valid;
      if (r2_valid) begin
        result <= w_res;
        ovf    <= w_ovf;
        nan    <= w_nan;
      end
    end
  end

endmodule

// File: tb/tb_fp_to_fixed_pipe.sv
// Scoreboard bench: three converter configurations share one stimulus stream;
// expected words come from an integer reference model of the conversion.
module tb_fp_to_fixed_pipe;

  logic        clk = 1'b0;
  logic        rst_n, clk_en, in_valid;
  logic [31:0] dataa;

  logic        ov_a, ovf_a, nan_a;
  logic [21:0] res_a;
  logic        ov_t, ovf_t, nan_t;
  logic [21:0] res_t;
  logic        ov_s, ovf_s, nan_s;
  logic [15:0] res_s;

  int n_total = 0;
  int n_bad   = 0;
  logic en_seen = 1'b0;
  logic [63:0] q_a[$], q_t[$], q_s[$];

  always #5 clk = ~clk;

  fp_to_fixed_pipe #(.OUT_W(22), .FRAC_W(20), .ROUND_NEAR(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .in_valid(in_valid), .dataa(dataa),
    .out_valid(ov_a), .result(res_a), .ovf(ovf_a), .nan(nan_a));

  fp_to_fixed_pipe #(.OUT_W(22), .FRAC_W(20), .ROUND_NEAR(0)) dut_t (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .in_valid(in_valid), .dataa(dataa),
    .out_valid(ov_t), .result(res_t), .ovf(ovf_t), .nan(nan_t));

  fp_to_fixed_pipe #(.OUT_W(16), .FRAC_W(12), .ROUND_NEAR(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .in_valid(in_valid), .dataa(dataa),
    .out_valid(ov_s), .result(res_s), .ovf(ovf_s), .nan(nan_s));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: exact value sig*2^sh, rounded by remainder compare; packed {nan,ovf,result}
  function automatic logic [63:0] model(input logic [31:0] f, input int ow, input int fw,
                                        input bit rne);
    int e, sh, rs;
    longint sig, mag, q, rem, half, lim, res;
    bit over, ov;
    e = int'(f[30:23]);
    sig = longint'({1'b1, f[22:0]});
    lim = longint'(1) << (ow - 1);
    over = 1'b0; mag = 0; q = 0; rem = 0; half = 0;
    if (e == 255 && f[22:0] != 23'd0) return {30'd0, 1'b1, 1'b0, 32'd0};
    if (e == 0) return 64'd0;
    if (e == 255) begin
      over = 1'b1;
    end else begin
      sh = e - 150 + fw;
      if (sh >= 0) begin
        if (sh > 40) over = 1'b1;
        else mag = sig << sh;
      end else begin
        rs = -sh;
        if (rs < 40) begin
          q = sig >> rs;
          rem = sig - (q << rs);
          half = longint'(1) << (rs - 1);
          mag = q;
          if (rne && (rem > half || (rem == half && q[0]))) mag = mag + 1;
        end
      end
    end
    if (f[31]) begin
      if (over || mag > lim) begin res = -lim; ov = 1'b1; end
      else begin res = -mag; ov = 1'b0; end
    end else begin
      if (over || mag >= lim) begin res = lim - 1; ov = 1'b1; end
      else begin res = mag; ov = 1'b0; end
    end
    res = res & ((longint'(1) << ow) - 1);
    return {30'd0, 1'b0, ov, res[31:0]};
  endfunction

  task automatic send(input logic [31:0] f);
    @(negedge clk);
    in_valid = 1'b1;
    clk_en   = 1'b1;
    dataa    = f;
    q_a.push_back(model(f, 22, 20, 1'b1));
    q_t.push_back(model(f, 22, 20, 1'b0));
    q_s.push_back(model(f, 16, 12, 1'b1));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      clk_en   = 1'b1;
    end
  endtask

  always @(posedge clk) en_seen <= rst_n & clk_en;

  always @(negedge clk) begin
    if (en_seen && ov_a) begin
      if (q_a.size() == 0) check("a_extra", 64'd1, 64'd0);
      else check("a_out", {30'd0, nan_a, ovf_a, 32'(res_a)}, q_a.pop_front());
    end
    if (en_seen && ov_t) begin
      if (q_t.size() == 0) check("t_extra", 64'd1, 64'd0);
      else check("t_out", {30'd0, nan_t, ovf_t, 32'(res_t)}, q_t.pop_front());
    end
    if (en_seen && ov_s) begin
      if (q_s.size() == 0) check("s_extra", 64'd1, 64'd0);
      else check("s_out", {30'd0, nan_s, ovf_s, 32'(res_s)}, q_s.pop_front());
    end
  end

  logic [31:0] directed [13] = '{32'h3F0B851F, 32'hBF800000, 32'hC0000000, 32'h40800000,
                                 32'hFF800000, 32'h35000000, 32'h35C00000, 32'hB5C00000,
                                 32'h00000001, 32'h7FC00000, 32'h3F800000, 32'h80000000,
                                 32'h7F800000};
  logic [24:0] snap;

  initial begin
    rst_n = 1'b0; clk_en = 1'b1; in_valid = 1'b0; dataa = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_valid", {63'd0, ov_a}, 64'd0);
    check("rst_result", 64'(res_a), 64'd0);
    check("rst_flags", {62'd0, ovf_a, nan_a}, 64'd0);
    rst_n = 1'b1;
    idle(2);

    // latency: out_valid exactly on the third enabled edge
    send(32'h3F0B851F);
    @(posedge clk); #1 check("lat1", {63'd0, ov_a}, 64'd0);
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1 check("lat2", {63'd0, ov_a}, 64'd0);
    @(posedge clk); #1 check("lat3", {63'd0, ov_a}, 64'd1);
    idle(4);

    foreach (directed[i]) send(directed[i]);
    idle(5);

    for (int i = 0; i < 60; i++) begin
      send({1'($urandom_range(0, 1)), 8'($urandom_range(100, 140)), 23'($urandom)});
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(5);

    // stall mid-stream: outputs must freeze, nothing lost or duplicated
    for (int i = 0; i < 4; i++) send({1'($urandom_range(0, 1)), 8'($urandom_range(118, 128)), 23'($urandom)});
    @(negedge clk);
    in_valid = 1'b0; clk_en = 1'b0;
    snap = {ov_a, ovf_a, nan_a, res_a};
    repeat (5) begin
      @(negedge clk);
      check("stall_hold", 64'({ov_a, ovf_a, nan_a, res_a}), 64'(snap));
    end
    clk_en = 1'b1;
    idle(6);

    // reset with two operands in flight
    send(32'h3F000000);
    send(32'hBE800000);
    @(posedge clk); #2;
    rst_n = 1'b0;
    q_a.delete(); q_t.delete(); q_s.delete();
    #1;
    check("rst_mid_valid", {61'd0, ov_a, ov_t, ov_s}, 64'd0);
    check("rst_mid_res_a", 64'(res_a), 64'd0);
    check("rst_mid_res_s", 64'(res_s), 64'd0);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    idle(8);

    send(32'h3F0B851F);
    idle(6);
    check("drain", 64'(q_a.size() + q_t.size() + q_s.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
